// File: rtl/spi_minion_shift_core_if.sv
// Handshake bundle between the SPI minion shift core and the SPI minion adapter.
//   pull_en           core -> adapter  one-cycle request for the next response word
//   pull_msg_val      adapter -> core  response word valid
//   pull_msg_spc      adapter -> core  adapter has space for a write
//   pull_msg_data     adapter -> core  response data (nbits-2 bits)
//   push_en           core -> adapter  one-cycle strobe, a complete frame was captured
//   push_msg_val_wrt  core -> adapter  write flag of the last completed frame
//   push_msg_val_rd   core -> adapter  read flag of the last completed frame
//   push_msg_data     core -> adapter  data of the last completed frame (nbits-2 bits)
// The master modport is the shift-core side, the slave modport is the adapter side.
interface spi_minion_shift_core_if #(
  parameter int nbits = 8
);
  logic             pull_en;
  logic             pull_msg_val;
  logic             pull_msg_spc;
  logic [nbits-3:0] pull_msg_data;
  logic             push_en;
  logic             push_msg_val_wrt;
  logic             push_msg_val_rd;
  logic [nbits-3:0] push_msg_data;

  modport master (
    output pull_en,
    input  pull_msg_val,
    input  pull_msg_spc,
    input  pull_msg_data,
    output push_en,
    output push_msg_val_wrt,
    output push_msg_val_rd,
    output push_msg_data
  );

  modport slave (
    input  pull_en,
    output pull_msg_val,
    output pull_msg_spc,
    output pull_msg_data,
    input  push_en,
    input  push_msg_val_wrt,
    input  push_msg_val_rd,
    input  push_msg_data
  );
endinterface

// File: rtl/spi_minion_shift_core.sv
// SPI minion physical stage (mode 0, MSB first).
// Oversamples cs/sclk/mosi in the clk domain, deserializes every chip-select
// frame of nbits bits into a push transaction, and at the start of each frame
// pulls one response word from the adapter and serializes it onto miso.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   cs     SPI chip select, active-low, asynchronous to clk
//   sclk   SPI clock, asynchronous to clk
//   mosi   SPI data in
//   miso   SPI data out, registered, 0 outside a frame
//   bus    pull/push handshake with the adapter (master side)
// Frame layout: bit[nbits-1] write-valid, bit[nbits-2] read-valid, rest data.
module spi_minion_shift_core #(
  parameter int nbits       = 8,
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  spi_minion_shift_core_if.master bus
);

  localparam int cnt_w = $clog2(nbits + 1);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(nbits);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains; bit [sync_stages-1] is the synchronized value.
  logic [sync_stages-1:0] cs_sync_r;
  logic [sync_stages-1:0] sclk_sync_r;
  logic [sync_stages-1:0] mosi_sync_r;
  logic                   cs_hist_r;
  logic                   sclk_hist_r;

  logic cs_s;
  logic sclk_s;
  logic mosi_s;
  logic cs_fall_s;
  logic cs_rise_s;
  logic sclk_rise_s;

  state_t           state_r;
  state_t           state_next_s;
  logic [nbits-1:0] shreg_r;
  logic [nbits-1:0] shreg_next_s;
  logic [cnt_w-1:0] cnt_r;
  logic [cnt_w-1:0] cnt_next_s;
  logic             pull_en_r;
  logic             pull_en_next_s;
  logic             push_en_r;
  logic             push_en_next_s;
  logic             push_wrt_r;
  logic             push_wrt_next_s;
  logic             push_rd_r;
  logic             push_rd_next_s;
  logic [nbits-3:0] push_data_r;
  logic [nbits-3:0] push_data_next_s;
  logic             miso_r;

  // Pin synchronizers plus one history flop for edge detection on cs and sclk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_r   <= {sync_stages{1'b1}};
      sclk_sync_r <= {sync_stages{1'b0}};
      mosi_sync_r <= {sync_stages{1'b0}};
      cs_hist_r   <= 1'b1;
      sclk_hist_r <= 1'b0;
    end else begin
      cs_sync_r   <= {cs_sync_r[sync_stages-2:0], cs};
      sclk_sync_r <= {sclk_sync_r[sync_stages-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[sync_stages-2:0], mosi};
      cs_hist_r   <= cs_sync_r[sync_stages-1];
      sclk_hist_r <= sclk_sync_r[sync_stages-1];
    end
  end

  assign cs_s        = cs_sync_r[sync_stages-1];
  assign sclk_s      = sclk_sync_r[sync_stages-1];
  assign mosi_s      = mosi_sync_r[sync_stages-1];
  assign cs_fall_s   = cs_hist_r & ~cs_s;
  assign cs_rise_s   = ~cs_hist_r & cs_s;
  // sclk falls need no action: miso simply follows the MSB register.
  assign sclk_rise_s = ~sclk_hist_r & sclk_s;

  // Next-state and next-register logic for the frame state machine.
  always_comb begin
    state_next_s     = state_r;
    shreg_next_s     = shreg_r;
    cnt_next_s       = cnt_r;
    pull_en_next_s   = 1'b0;
    push_en_next_s   = 1'b0;
    push_wrt_next_s  = push_wrt_r;
    push_rd_next_s   = push_rd_r;
    push_data_next_s = push_data_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          pull_en_next_s = 1'b1;
          shreg_next_s   = {bus.pull_msg_val, bus.pull_msg_spc, bus.pull_msg_data};
          cnt_next_s     = {cnt_w{1'b0}};
          state_next_s   = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          // Only a frame with a full bit count is handed over; short frames abort.
          if (cnt_r == cnt_max) begin
            push_en_next_s   = 1'b1;
            push_wrt_next_s  = shreg_r[nbits-1];
            push_rd_next_s   = shreg_r[nbits-2];
            push_data_next_s = shreg_r[nbits-3:0];
          end else begin
            push_en_next_s = 1'b0;
          end
          state_next_s = ST_IDLE;
        end else if (sclk_rise_s) begin
          shreg_next_s = {shreg_r[nbits-2:0], mosi_s};
          if (cnt_r != cnt_max) begin
            cnt_next_s = cnt_r + cnt_one;
          end else begin
            cnt_next_s = cnt_r;
          end
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; miso is the registered MSB, gated by ACTIVE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {nbits{1'b0}};
      cnt_r       <= {cnt_w{1'b0}};
      pull_en_r   <= 1'b0;
      push_en_r   <= 1'b0;
      push_wrt_r  <= 1'b0;
      push_rd_r   <= 1'b0;
      push_data_r <= {(nbits-2){1'b0}};
      miso_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      shreg_r     <= shreg_next_s;
      cnt_r       <= cnt_next_s;
      pull_en_r   <= pull_en_next_s;
      push_en_r   <= push_en_next_s;
      push_wrt_r  <= push_wrt_next_s;
      push_rd_r   <= push_rd_next_s;
      push_data_r <= push_data_next_s;
      miso_r      <= (state_r == ST_ACTIVE) ? shreg_r[nbits-1] : 1'b0;
    end
  end

  assign miso                 = miso_r;
  assign bus.pull_en          = pull_en_r;
  assign bus.push_en          = push_en_r;
  assign bus.push_msg_val_wrt = push_wrt_r;
  assign bus.push_msg_val_rd  = push_rd_r;
  assign bus.push_msg_data    = push_data_r;

endmodule
